// File: rtl/byte_fifo_buffer.sv
// rtl/byte_fifo_buffer.sv - circular byte FIFO with peek, sticky flags and CTS hysteresis
// Sits between the serial receiver and the SPI transmit sequencer.
module byte_fifo_buffer #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 5,
  parameter int CTS_OFF = 28,
  parameter int CTS_ON  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  BYTEIN,
  input  logic              READ,
  output logic [WIDTH-1:0]  BYTEOUT,
  output logic              VALID,
  input  logic              PEEK,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [WIDTH-1:0]  PEEKOUT,
  output logic              PEEK_VALID,
  input  logic              RTS,
  output logic              CTS,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_CTS_OFF = (ADDR_W+1)'(CTS_OFF);
  localparam logic [ADDR_W:0] LP_CTS_ON  = (ADDR_W+1)'(CTS_ON);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [WIDTH-1:0]  r_byteout;
  logic [WIDTH-1:0]  r_peekout;
  logic              r_valid;
  logic              r_peek_valid;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_grant;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [ADDR_W:0]   w_count_nxt;
  logic [ADDR_W-1:0] w_peek_addr;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == LP_DEPTH);
  // CLEAR wins over every request in the same cycle.
  assign w_pop       = READ & ~w_empty & ~CLEAR;
  assign w_push      = LOAD & (~w_full | w_pop) & ~CLEAR;
  assign w_peek_addr = r_rd_ptr + ADDR;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push)
      w_count_nxt = r_count - 1'b1;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wr_ptr] <= BYTEIN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_byteout    <= '0;
      r_peekout    <= '0;
      r_valid      <= 1'b0;
      r_peek_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_grant      <= 1'b1;
    end else if (CLEAR) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_byteout    <= '0;
      r_peekout    <= '0;
      r_valid      <= 1'b0;
      r_peek_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_grant      <= 1'b1;
    end else begin
      r_valid      <= w_pop;
      r_peek_valid <= 1'b0;
      if (w_pop) begin
        r_byteout <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (PEEK) begin
        r_peekout    <= r_mem[w_peek_addr];
        r_peek_valid <= ({1'b0, ADDR} < r_count);
      end
      if (LOAD && w_full && !w_pop)
        r_overflow <= 1'b1;
      if (READ && w_empty)
        r_underflow <= 1'b1;
      r_count <= w_count_nxt;
      // Hysteresis: between the thresholds the grant holds its value.
      if (w_count_nxt >= LP_CTS_OFF)
        r_grant <= 1'b0;
      else if (w_count_nxt <= LP_CTS_ON)
        r_grant <= 1'b1;
    end
  end

  assign BYTEOUT    = r_byteout;
  assign VALID      = r_valid;
  assign PEEKOUT    = r_peekout;
  assign PEEK_VALID = r_peek_valid;
  assign COUNT      = r_count;
  assign FULL       = w_full;
  assign EMPTY      = w_empty;
  assign OVERFLOW   = r_overflow;
  assign UNDERFLOW  = r_underflow;
  assign CTS        = RTS & r_grant;

endmodule

// File: tb/tb_byte_fifo_buffer.sv
// tb/tb_byte_fifo_buffer.sv - self-checking bench for byte_fifo_buffer
// Scoreboard queue holds expected FIFO contents; pops are compared as VALID pulses.
module tb_byte_fifo_buffer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLEAR = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] BYTEIN = '0;
  logic       READ = 1'b0;
  logic [7:0] BYTEOUT;
  logic       VALID;
  logic       PEEK = 1'b0;
  logic [4:0] ADDR = '0;
  logic [7:0] PEEKOUT;
  logic       PEEK_VALID;
  logic       RTS = 1'b0;
  logic       CTS;
  logic [5:0] COUNT;
  logic       FULL;
  logic       EMPTY;
  logic       OVERFLOW;
  logic       UNDERFLOW;

  byte_fifo_buffer dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .LOAD(LOAD), .BYTEIN(BYTEIN),
    .READ(READ), .BYTEOUT(BYTEOUT), .VALID(VALID), .PEEK(PEEK), .ADDR(ADDR),
    .PEEKOUT(PEEKOUT), .PEEK_VALID(PEEK_VALID), .RTS(RTS), .CTS(CTS),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] q_exp [$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_grant = 1'b1;
  logic       exp_valid;
  logic [7:0] exp_byte = '0;

  // Drives one clock of push/pop and advances the reference model.
  task automatic do_cycle(input logic ld, input logic [7:0] d, input logic rd);
    logic pop_ok, push_ok;
    pop_ok  = rd && (m_count > 0);
    push_ok = ld && ((m_count < 32) || pop_ok);
    if (ld && m_count == 32 && !pop_ok) m_ovf = 1'b1;
    if (rd && m_count == 0) m_unf = 1'b1;
    LOAD = ld; BYTEIN = d; READ = rd;
    @(posedge CLK); #1;
    LOAD = 1'b0; READ = 1'b0;
    exp_valid = pop_ok;
    if (pop_ok) exp_byte = q_exp.pop_front();
    if (push_ok) q_exp.push_back(d);
    m_count = q_exp.size();
    if (m_count >= 28) m_grant = 1'b0;
    else if (m_count <= 16) m_grant = 1'b1;
  endtask

  task automatic do_clear(input logic ld);
    CLEAR = 1'b1; LOAD = ld; BYTEIN = 8'hEE;
    @(posedge CLK); #1;
    CLEAR = 1'b0; LOAD = 1'b0;
    q_exp.delete();
    m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_grant = 1'b1; exp_byte = '0;
  endtask

  task automatic test_reset();
    RTS = 1'b0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (COUNT !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    n_checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got %b%b exp 10", EMPTY, FULL); end
    n_checks++; if (VALID !== 1'b0 || PEEK_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valids got %b%b exp 00", VALID, PEEK_VALID); end
    n_checks++; if (BYTEOUT !== 8'h00 || PEEKOUT !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h %h exp 00 00", BYTEOUT, PEEKOUT); end
    n_checks++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", OVERFLOW, UNDERFLOW); end
    n_checks++; if (CTS !== 1'b0) begin n_fail++; $display("FAIL reset_cts_rts0 got %b exp 0", CTS); end
    RTS = 1'b1; #1;
    n_checks++; if (CTS !== 1'b1) begin n_fail++; $display("FAIL reset_cts_rts1 got %b exp 1", CTS); end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_fill_drain();
    do_clear(1'b0);
    for (int i = 1; i <= 32; i++) begin
      do_cycle(1'b1, 8'(i), 1'b0);
      n_checks++; if (COUNT !== 6'(m_count)) begin n_fail++; $display("FAIL fill_count got %0d exp %0d", COUNT, m_count); end
    end
    n_checks++; if (FULL !== 1'b1 || EMPTY !== 1'b0) begin n_fail++; $display("FAIL fill_full got %b%b exp 10", FULL, EMPTY); end
    for (int i = 0; i < 32; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1);
      n_checks++; if (VALID !== exp_valid || BYTEOUT !== exp_byte) begin n_fail++; $display("FAIL drain_data got %b/%h exp %b/%h", VALID, BYTEOUT, exp_valid, exp_byte); end
    end
    n_checks++; if (COUNT !== 6'd0 || EMPTY !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %0d/%b exp 0/1", COUNT, EMPTY); end
    n_checks++; if (OVERFLOW !== m_ovf || UNDERFLOW !== m_unf) begin n_fail++; $display("FAIL drain_flags got %b%b exp %b%b", OVERFLOW, UNDERFLOW, m_ovf, m_unf); end
    do_cycle(1'b0, 8'h00, 1'b0);
    n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL valid_pulse got %b exp 0", VALID); end
  endtask

  task automatic test_overflow();
    do_clear(1'b0);
    for (int i = 1; i <= 32; i++) do_cycle(1'b1, 8'(i), 1'b0);
    do_cycle(1'b1, 8'hAA, 1'b0);
    n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", OVERFLOW); end
    n_checks++; if (COUNT !== 6'd32) begin n_fail++; $display("FAIL ovf_count got %0d exp 32", COUNT); end
    do_cycle(1'b1, 8'hBB, 1'b1);
    n_checks++; if (VALID !== 1'b1 || BYTEOUT !== 8'h01) begin n_fail++; $display("FAIL full_pushpop got %b/%h exp 1/01", VALID, BYTEOUT); end
    n_checks++; if (COUNT !== 6'd32) begin n_fail++; $display("FAIL full_pushpop_count got %0d exp 32", COUNT); end
    for (int i = 0; i < 32; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1);
      n_checks++; if (VALID !== exp_valid || BYTEOUT !== exp_byte) begin n_fail++; $display("FAIL ovf_drain got %b/%h exp %b/%h", VALID, BYTEOUT, exp_valid, exp_byte); end
    end
    n_checks++; if (BYTEOUT !== 8'hBB) begin n_fail++; $display("FAIL ovf_last got %h exp bb", BYTEOUT); end
  endtask

  task automatic test_underflow();
    do_clear(1'b0);
    do_cycle(1'b1, 8'h5C, 1'b1);
    n_checks++; if (VALID !== 1'b0 || UNDERFLOW !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b/%b exp 0/1", VALID, UNDERFLOW); end
    n_checks++; if (COUNT !== 6'd1) begin n_fail++; $display("FAIL unf_count got %0d exp 1", COUNT); end
    do_cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (VALID !== 1'b1 || BYTEOUT !== 8'h5C) begin n_fail++; $display("FAIL unf_pop got %b/%h exp 1/5c", VALID, BYTEOUT); end
  endtask

  task automatic test_cts();
    do_clear(1'b0);
    RTS = 1'b1;
    for (int i = 0; i < 28; i++) begin
      do_cycle(1'b1, 8'(8'h40 + i), 1'b0);
      n_checks++; if (CTS !== m_grant) begin n_fail++; $display("FAIL cts_fill at %0d got %b exp %b", m_count, CTS, m_grant); end
    end
    n_checks++; if (CTS !== 1'b0) begin n_fail++; $display("FAIL cts_off got %b exp 0", CTS); end
    while (m_count > 16) begin
      do_cycle(1'b0, 8'h00, 1'b1);
      n_checks++; if (CTS !== m_grant || BYTEOUT !== exp_byte) begin n_fail++; $display("FAIL cts_drain at %0d got %b/%h exp %b/%h", m_count, CTS, BYTEOUT, m_grant, exp_byte); end
    end
    n_checks++; if (CTS !== 1'b1) begin n_fail++; $display("FAIL cts_on got %b exp 1", CTS); end
  endtask

  task automatic test_wrap_peek();
    do_clear(1'b0);
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b1, 8'(8'h0D + i), (i >= 5));
      n_checks++; if (VALID !== exp_valid || (exp_valid && BYTEOUT !== exp_byte)) begin n_fail++; $display("FAIL wrap_pop got %b/%h exp %b/%h", VALID, BYTEOUT, exp_valid, exp_byte); end
    end
    for (int k = 0; k < 4; k++) begin
      logic [4:0] a;
      logic       ev;
      logic [7:0] ed;
      a = (k == 0) ? 5'd2 : (k == 1) ? 5'd7 : (k == 2) ? 5'd4 : 5'd5;
      ev = (int'(a) < m_count);
      ed = ev ? q_exp[a] : 8'h00;
      PEEK = 1'b1; ADDR = a;
      @(posedge CLK); #1;
      PEEK = 1'b0;
      n_checks++; if (PEEK_VALID !== ev || (ev && PEEKOUT !== ed)) begin n_fail++; $display("FAIL peek addr %0d got %b/%h exp %b/%h", a, PEEK_VALID, PEEKOUT, ev, ed); end
      n_checks++; if (COUNT !== 6'd5) begin n_fail++; $display("FAIL peek_count got %0d exp 5", COUNT); end
    end
  endtask

  task automatic test_clear_reset();
    do_clear(1'b0);
    for (int i = 0; i < 33; i++) do_cycle(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 22; i++) do_cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (COUNT !== 6'd10 || OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL pre_clear got %0d/%b exp 10/1", COUNT, OVERFLOW); end
    do_clear(1'b1);
    n_checks++; if (COUNT !== 6'd0 || OVERFLOW !== 1'b0 || EMPTY !== 1'b1) begin n_fail++; $display("FAIL clear got %0d/%b/%b exp 0/0/1", COUNT, OVERFLOW, EMPTY); end
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 8'h77, 1'b1);
    LOAD = 1'b1; BYTEIN = 8'h99; READ = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    n_checks++; if (COUNT !== 6'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin n_fail++; $display("FAIL async_count got %0d/%b/%b exp 0/1/0", COUNT, EMPTY, FULL); end
    n_checks++; if (VALID !== 1'b0 || BYTEOUT !== 8'h00 || UNDERFLOW !== 1'b0 || CTS !== RTS) begin n_fail++; $display("FAIL async_outs got %b/%h/%b/%b exp 0/00/0/%b", VALID, BYTEOUT, UNDERFLOW, CTS, RTS); end
    LOAD = 1'b0; READ = 1'b0;
    #2;
    RESET = 1'b0;
    q_exp.delete(); m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_grant = 1'b1;
    @(posedge CLK); #1;
    do_cycle(1'b1, 8'h3C, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (VALID !== 1'b1 || BYTEOUT !== 8'h3C || COUNT !== 6'd0) begin n_fail++; $display("FAIL post_reset got %b/%h/%0d exp 1/3c/0", VALID, BYTEOUT, COUNT); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_cts();
    test_wrap_peek();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
